user_io_spi: RTL and testbench

Parametrised single-clock successor to the MiST user_io SPI command slave. Oversamples the ARM controller's SPI link in `clk_sys` and decodes the command byte. It drives buttons/switches, a configurable number and width of joysticks, and a status word of configurable width. It also provides a bidirectional serial channel with a FIFO in each direction; the host-to-core direction is new. It sits between the top-level SPI pins and core logic, replacing the SCK-clocked variant wherever no SD or PS/2 traffic is needed.

---
 rtl/user_io_pkg.sv | 34 +++
 rtl/user_io_spi_if.sv | 19 +
 rtl/user_io_fifo.sv | 47 ++++
 rtl/user_io_spi.sv | 214 +++++++++++++++++++++
 tb/tb_user_io_spi.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/user_io_pkg.sv
// Shared command codes, serial status byte layout and defaults for the SPI user_io slave.
package user_io_pkg;

    localparam logic [7:0] CMD_BUT_SW   = 8'h01;
    localparam logic [7:0] CMD_STATUS   = 8'h15;
    localparam logic [7:0] CMD_SER      = 8'h1b;
    localparam logic [7:0] CMD_STATUS64 = 8'h1e;
    localparam logic [7:0] CMD_SER_IN   = 8'h1f;
    localparam logic [7:0] CMD_JOY0     = 8'h60;
    localparam logic [7:0] CMD_FEATURES = 8'h80;

    localparam logic [7:0] DEFAULT_CORE_TYPE = 8'ha4;

    localparam int unsigned BYTE_CNT_W = 10;
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = 10'd1023;

    // Status byte returned on odd bytes of CMD_SER.
    localparam logic [5:0] SER_STAT_TAG = 6'b100000;

    typedef struct packed {
        logic [5:0] tag;
        logic       in_ovf;
        logic       out_avail;
    } ser_status_t;

    function automatic logic [7:0] ser_status_byte(input logic in_ovf, input logic out_avail);
        ser_status_t s;
        s.tag       = SER_STAT_TAG;
        s.in_ovf    = in_ovf;
        s.out_avail = out_avail;
        return 8'(s);
    endfunction

endpackage

// File: rtl/user_io_spi_if.sv
// Bidirectional serial byte channel between user_io_spi (slave) and core logic (master).
interface user_io_spi_if;
    logic [7:0] ser_out_data;
    logic       ser_out_strobe;
    logic       ser_out_full;
    logic [7:0] ser_in_data;
    logic       ser_in_valid;
    logic       ser_in_ready;

    modport master (
        output ser_out_data, ser_out_strobe, ser_in_ready,
        input  ser_out_full, ser_in_data, ser_in_valid
    );

    modport slave (
        input  ser_out_data, ser_out_strobe, ser_in_ready,
        output ser_out_full, ser_in_data, ser_in_valid
    );
endinterface

// File: rtl/user_io_fifo.sv
// Synchronous FIFO; a pop on the same cycle as a push to a full FIFO frees the slot first.
module user_io_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 6
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count
);
    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam int unsigned CNT_W = DEPTH_BITS + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign pop_data  = empty ? '0 : mem[rd_ptr[DEPTH_BITS-1:0]];

    // Pointer update, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + CNT_W'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk_sys) begin
        if (do_push_c) mem[wr_ptr[DEPTH_BITS-1:0]] <= push_data;
    end
endmodule

// File: rtl/user_io_spi.sv
// Oversampled SPI command slave: buttons/switches, joysticks, status word and serial FIFOs.
module user_io_spi
    import user_io_pkg::*;
#(
    parameter int unsigned JOY_NUM       = 5,
    parameter int unsigned JOY_BYTES     = 4,
    parameter int unsigned STATUS_BYTES  = 8,
    parameter int unsigned SER_FIFO_BITS = 6,
    parameter logic [7:0]  CORE_TYPE     = DEFAULT_CORE_TYPE,
    parameter logic [31:0] FEATURES      = 32'h0
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic                             SPI_CLK,
    input  logic                             SPI_SS_IO,
    input  logic                             SPI_MOSI,
    output wire                              SPI_MISO,
    output logic [1:0]                       buttons,
    output logic [1:0]                       switches,
    output logic [JOY_NUM*JOY_BYTES*8-1:0]   joystick,
    output logic [JOY_NUM-1:0]               joy_strobe,
    output logic [8*STATUS_BYTES-1:0]        status,
    output logic                             status_strobe,
    user_io_spi_if.slave                     ser
);
    logic [2:0]            sck_s, ss_s;
    logic [1:0]            mosi_s;
    logic                  sck_rise_c, sck_fall_c, ss_rise_c, active_c;
    logic                  armed, byte_done, fire_q;
    logic [2:0]            bit_cnt;
    logic [6:0]            sreg, tx_q;
    logic [BYTE_CNT_W-1:0] byte_cnt, done_idx;
    logic [7:0]            cmd, byte_q, next_byte_c;
    logic                  miso_q, ser_avail_q, in_ovf, stat_pend;
    logic [JOY_NUM-1:0]    joy_pend;
    logic [2:0]            joy_n_c;
    logic                  joy_valid_c, known_c;
    logic [7:0]            out_head;
    logic                  out_empty, in_full, in_empty, out_pop_c, in_push_c, in_pop_c;
    logic [SER_FIFO_BITS:0] unused_out_count, unused_in_count;

    assign sck_rise_c  = sck_s[1] & ~sck_s[2];
    assign sck_fall_c  = ~sck_s[1] & sck_s[2];
    assign ss_rise_c   = ss_s[1] & ~ss_s[2];
    assign active_c    = armed & ~ss_s[1];
    assign joy_n_c     = cmd[2:0];
    assign joy_valid_c = (cmd[7:3] == CMD_JOY0[7:3]) && ({29'd0, joy_n_c} < JOY_NUM);
    assign known_c     = joy_valid_c || cmd == CMD_BUT_SW || cmd == CMD_STATUS || cmd == CMD_SER
                      || cmd == CMD_STATUS64 || cmd == CMD_SER_IN || cmd == CMD_FEATURES;
    assign SPI_MISO    = SPI_SS_IO ? 1'bz : miso_q;

    assign out_pop_c   = byte_done && cmd == CMD_SER && done_idx != '0 && !done_idx[0] && ser_avail_q;
    assign in_push_c   = byte_done && cmd == CMD_SER_IN && done_idx != '0;
    assign in_pop_c    = ~in_empty & ser.ser_in_ready;
    assign ser.ser_in_valid = ~in_empty;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sck_s  <= 3'b000;
            ss_s   <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sck_s  <= {sck_s[1:0], SPI_CLK};
            ss_s   <= {ss_s[1:0], SPI_SS_IO};
            mosi_s <= {mosi_s[0], SPI_MOSI};
        end
    end

    // Receive shifter and bit/byte counters; armed blocks decoding until SS has been seen idle.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            armed     <= 1'b0;
            bit_cnt   <= '0;
            sreg      <= '0;
            byte_cnt  <= '0;
            done_idx  <= '0;
            cmd       <= '0;
            byte_q    <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (ss_s[1]) armed <= 1'b1;
            if (!active_c) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (sck_rise_c) begin
                sreg    <= {sreg[5:0], mosi_s[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    byte_q    <= {sreg, mosi_s[1]};
                    done_idx  <= byte_cnt;
                    if (byte_cnt == '0) cmd <= {sreg, mosi_s[1]};
                    if (byte_cnt != BYTE_CNT_MAX) byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                end
            end
        end
    end

    // Byte the host will read next, chosen at the SCK fall that starts it.
    always_comb begin
        next_byte_c = 8'h00;
        if (byte_cnt == '0) begin
            next_byte_c = CORE_TYPE;
        end else if (cmd == CMD_SER) begin
            if (byte_cnt[0]) next_byte_c = ser_status_byte(in_ovf, ~out_empty);
            else             next_byte_c = ser_avail_q ? out_head : 8'h00;
        end else if (cmd == CMD_FEATURES) begin
            for (int k = 0; k < 4; k++)
                if (byte_cnt == BYTE_CNT_W'(k + 1)) next_byte_c = FEATURES[8*(3-k) +: 8];
        end else if (!known_c) begin
            next_byte_c = cmd;
        end
    end

    // MISO shifter: preloaded with CORE_TYPE while idle, shifts on SCK fall.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            miso_q      <= 1'b0;
            tx_q        <= '0;
            ser_avail_q <= 1'b0;
        end else if (!active_c) begin
            miso_q <= CORE_TYPE[7];
            tx_q   <= CORE_TYPE[6:0];
        end else if (sck_fall_c) begin
            if (bit_cnt == 3'd0) begin
                miso_q <= next_byte_c[7];
                tx_q   <= next_byte_c[6:0];
                if (cmd == CMD_SER && byte_cnt[0]) ser_avail_q <= ~out_empty;
            end else begin
                miso_q <= tx_q[6];
                tx_q   <= {tx_q[5:0], 1'b0};
            end
        end
    end

    // Register writes from completed bytes and end-of-transaction strobes.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            buttons       <= '0;
            switches      <= '0;
            joystick      <= '0;
            status        <= '0;
            joy_strobe    <= '0;
            status_strobe <= 1'b0;
            joy_pend      <= '0;
            stat_pend     <= 1'b0;
            fire_q        <= 1'b0;
            in_ovf        <= 1'b0;
        end else begin
            joy_strobe    <= '0;
            status_strobe <= 1'b0;
            fire_q        <= ss_rise_c & armed;
            if (fire_q) begin
                joy_strobe    <= joy_pend;
                status_strobe <= stat_pend;
                joy_pend      <= '0;
                stat_pend     <= 1'b0;
            end
            if (byte_done && done_idx != '0) begin
                if (cmd == CMD_BUT_SW && done_idx == BYTE_CNT_W'(1)) begin
                    buttons  <= byte_q[1:0];
                    switches <= byte_q[3:2];
                end
                if (cmd == CMD_STATUS && done_idx == BYTE_CNT_W'(1)) begin
                    status[7:0] <= byte_q;
                    stat_pend   <= 1'b1;
                end
                if (cmd == CMD_STATUS64) begin
                    for (int b = 0; b < int'(STATUS_BYTES); b++)
                        if (done_idx == BYTE_CNT_W'(b + 1)) begin
                            status[8*b +: 8] <= byte_q;
                            stat_pend        <= 1'b1;
                        end
                end
                if (joy_valid_c) begin
                    for (int j = 0; j < int'(JOY_NUM); j++)
                        for (int b = 0; b < int'(JOY_BYTES); b++)
                            if (joy_n_c == 3'(j) && done_idx == BYTE_CNT_W'(b + 1)) begin
                                joystick[8*(j*int'(JOY_BYTES) + b) +: 8] <= byte_q;
                                joy_pend[j] <= 1'b1;
                            end
                end
                if (cmd == CMD_SER && done_idx[0]) in_ovf <= 1'b0;
            end
            if (in_push_c && in_full && !in_pop_c) in_ovf <= 1'b1;
        end
    end

    user_io_fifo #(.WIDTH(8), .DEPTH_BITS(SER_FIFO_BITS)) u_out_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push      (ser.ser_out_strobe),
        .push_data (ser.ser_out_data),
        .pop       (out_pop_c),
        .pop_data  (out_head),
        .full      (ser.ser_out_full),
        .empty     (out_empty),
        .count     (unused_out_count)
    );

    user_io_fifo #(.WIDTH(8), .DEPTH_BITS(SER_FIFO_BITS)) u_in_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push      (in_push_c),
        .push_data (byte_q),
        .pop       (in_pop_c),
        .pop_data  (ser.ser_in_data),
        .full      (in_full),
        .empty     (in_empty),
        .count     (unused_in_count)
    );
endmodule

// File: tb/tb_user_io_spi.sv
// Directed bench for user_io_spi with a MISO scoreboard and a host-to-core stream scoreboard.
module tb_user_io_spi;
    localparam int unsigned JOY_NUM = 2, JOY_BYTES = 2, STATUS_BYTES = 8, SER_FIFO_BITS = 2;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic spi_clk = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0;
    wire  spi_miso;
    logic [1:0] buttons, switches;
    logic [JOY_NUM*JOY_BYTES*8-1:0] joystick;
    logic [JOY_NUM-1:0] joy_strobe;
    logic [8*STATUS_BYTES-1:0] status;
    logic status_strobe;

    user_io_spi_if ser_if ();

    user_io_spi #(
        .JOY_NUM(JOY_NUM), .JOY_BYTES(JOY_BYTES), .STATUS_BYTES(STATUS_BYTES),
        .SER_FIFO_BITS(SER_FIFO_BITS), .CORE_TYPE(8'ha4), .FEATURES(32'hdeadbeef)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .SPI_CLK(spi_clk), .SPI_SS_IO(spi_ss),
        .SPI_MOSI(spi_mosi), .SPI_MISO(spi_miso), .buttons(buttons), .switches(switches),
        .joystick(joystick), .joy_strobe(joy_strobe), .status(status),
        .status_strobe(status_strobe), .ser(ser_if)
    );

    always #5 clk_sys = ~clk_sys;

    int vecs = 0;
    int miscompares = 0;
    int joy_pulses = 0;
    int stat_pulses = 0;
    logic [JOY_NUM-1:0] joy_last = '0;
    logic [7:0] exp_q[$];
    logic [7:0] sin_q[$];

    // Count strobe pulses, sampled on the inactive clock edge.
    always @(negedge clk_sys) begin
        if (joy_strobe != '0) begin
            joy_pulses++;
            joy_last = joy_strobe;
        end
        if (status_strobe) stat_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vecs++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic want(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic ss_begin();
        spi_ss = 1'b0;
        #40;
    endtask

    task automatic ss_end();
        #40;
        spi_ss = 1'b1;
        repeat (20) @(negedge clk_sys);
    endtask

    // One mode-0 byte: MISO sampled just before each rising SCK edge, compared with the scoreboard.
    task automatic spi_byte(input logic [7:0] tx);
        logic [7:0] rx;
        rx = '0;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #40;
            rx[i] = spi_miso;
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
        end
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL miso_byte: observed %h with no expected byte queued", rx);
        end else begin
            check("miso_byte", 64'(rx), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic core_push(input logic [7:0] d);
        ser_if.ser_out_data   = d;
        ser_if.ser_out_strobe = 1'b1;
        @(negedge clk_sys);
        ser_if.ser_out_strobe = 1'b0;
    endtask

    initial begin
        int jp, sp;
        ser_if.ser_out_data   = 8'h00;
        ser_if.ser_out_strobe = 1'b0;
        ser_if.ser_in_ready   = 1'b0;
        repeat (4) @(negedge clk_sys);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);

        // Reset state
        check("rst_buttons", 64'(buttons), 64'h0);
        check("rst_switches", 64'(switches), 64'h0);
        check("rst_joystick", 64'(joystick), 64'h0);
        check("rst_status", status, 64'h0);
        check("rst_joy_strobe", 64'(joy_strobe), 64'h0);
        check("rst_status_strobe", 64'(status_strobe), 64'h0);
        check("rst_ser_in_valid", 64'(ser_if.ser_in_valid), 64'h0);
        check("rst_ser_in_data", 64'(ser_if.ser_in_data), 64'h0);
        check("rst_ser_out_full", 64'(ser_if.ser_out_full), 64'h0);

        // Buttons / switches
        want(8'ha4); want(8'h00);
        ss_begin(); spi_byte(8'h01); spi_byte(8'h0d); ss_end();
        check("buttons", 64'(buttons), 64'h1);
        check("switches", 64'(switches), 64'h3);

        // Joystick 1, excess byte ignored
        jp = joy_pulses;
        want(8'ha4); want(8'h00); want(8'h00); want(8'h00);
        ss_begin(); spi_byte(8'h61); spi_byte(8'h34); spi_byte(8'h12); spi_byte(8'hff); ss_end();
        check("joystick_61", 64'(joystick), 64'h1234_0000);
        check("joy_pulse_cnt", 64'(joy_pulses - jp), 64'h1);
        check("joy_pulse_val", 64'(joy_last), 64'h2);

        // Joystick index out of range: ignored, command byte echoed
        jp = joy_pulses;
        want(8'ha4); want(8'h62); want(8'h62);
        ss_begin(); spi_byte(8'h62); spi_byte(8'h55); spi_byte(8'h66); ss_end();
        check("joystick_62", 64'(joystick), 64'h1234_0000);
        check("joy_62_no_pulse", 64'(joy_pulses - jp), 64'h0);

        // Core-to-host serial read
        core_push(8'h41); core_push(8'h42);
        check("out_full_2", 64'(ser_if.ser_out_full), 64'h0);
        want(8'ha4); want(8'h81); want(8'h41); want(8'h81); want(8'h42); want(8'h80); want(8'h00);
        ss_begin(); spi_byte(8'h1b);
        for (int i = 0; i < 6; i++) spi_byte(8'h00);
        ss_end();
        check("out_full_after", 64'(ser_if.ser_out_full), 64'h0);

        // Out FIFO fills at 4 entries, fifth push dropped
        for (int i = 0; i < 5; i++) core_push(8'h50 + 8'(i));
        check("out_full_4", 64'(ser_if.ser_out_full), 64'h1);
        want(8'ha4);
        for (int i = 0; i < 4; i++) begin want(8'h81); want(8'h50 + 8'(i)); end
        want(8'h80);
        ss_begin(); spi_byte(8'h1b);
        for (int i = 0; i < 9; i++) spi_byte(8'h00);
        ss_end();
        check("out_full_drained", 64'(ser_if.ser_out_full), 64'h0);

        // Host-to-core: 5 bytes into a 4-deep FIFO
        want(8'ha4);
        for (int i = 0; i < 5; i++) want(8'h00);
        for (int i = 0; i < 4; i++) sin_q.push_back(8'ha0 + 8'(i));
        ss_begin(); spi_byte(8'h1f);
        for (int i = 0; i < 5; i++) spi_byte(8'ha0 + 8'(i));
        ss_end();
        check("ser_in_valid", 64'(ser_if.ser_in_valid), 64'h1);
        check("ser_in_hold_a", 64'(ser_if.ser_in_data), 64'ha0);
        repeat (3) @(negedge clk_sys);
        check("ser_in_hold_b", 64'(ser_if.ser_in_data), 64'ha0);
        want(8'ha4); want(8'h82); want(8'h00); want(8'h80);
        ss_begin(); spi_byte(8'h1b); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00); ss_end();

        // Drain the in FIFO
        ser_if.ser_in_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (ser_if.ser_in_valid) begin
                if (sin_q.size() == 0) begin
                    miscompares++;
                    $error("FAIL ser_in_extra: observed %h with no byte expected", ser_if.ser_in_data);
                end else begin
                    check("ser_in_data", 64'(ser_if.ser_in_data), 64'(sin_q.pop_front()));
                end
            end
            @(negedge clk_sys);
        end
        ser_if.ser_in_ready = 1'b0;
        check("ser_in_left", 64'(sin_q.size()), 64'h0);
        check("ser_in_idle", 64'(ser_if.ser_in_valid), 64'h0);

        // 64-bit status
        sp = stat_pulses;
        want(8'ha4);
        for (int i = 0; i < 8; i++) want(8'h00);
        ss_begin(); spi_byte(8'h1e);
        for (int i = 1; i <= 8; i++) spi_byte(8'(i));
        ss_end();
        check("status64", status, 64'h0807060504030201);
        check("status64_pulse", 64'(stat_pulses - sp), 64'h1);

        // Reset mid-transaction aborts it without a strobe
        sp = stat_pulses;
        want(8'ha4); want(8'h00); want(8'h00); want(8'h00);
        ss_begin(); spi_byte(8'h1e); spi_byte(8'h11); spi_byte(8'h12); spi_byte(8'h13);
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        spi_ss = 1'b1;
        repeat (20) @(negedge clk_sys);
        check("status_after_rst", status, 64'h0);
        check("status_rst_no_pulse", 64'(stat_pulses - sp), 64'h0);

        // Single status byte
        sp = stat_pulses;
        want(8'ha4); want(8'h00);
        ss_begin(); spi_byte(8'h15); spi_byte(8'h99); ss_end();
        check("status8", status, 64'h99);
        check("status8_pulse", 64'(stat_pulses - sp), 64'h1);

        // Features word
        want(8'ha4); want(8'hde); want(8'had); want(8'hbe); want(8'hef);
        ss_begin(); spi_byte(8'h80);
        for (int i = 0; i < 4; i++) spi_byte(8'h00);
        ss_end();

        check("miso_queue_left", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
